// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared constants, select type and one-hot decode for stream_demux14
package stream_demux_pkg;

  localparam int NPORTS = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] sel_t;

  // One-hot decode of a destination index
  function automatic logic [NPORTS-1:0] decode_sel(input sel_t sel);
    logic [NPORTS-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/stream_pipe_reg1.sv
// rtl/stream_pipe_reg1.sv - single-entry val/rdy pipeline register with pipe-style ready bypass
module stream_pipe_reg1 #(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg
);

  logic               full;
  logic [p_nbits-1:0] data_q;
  logic               enq_fire;
  logic               deq_fire;

  // Ready when empty, or when the current entry leaves this same cycle
  always_comb begin
    enq_rdy  = ~full | deq_rdy;
    enq_fire = enq_val & enq_rdy;
    deq_fire = full & deq_rdy;
  end

  // Occupancy and data: a fill wins over a drain, so fill+drain keeps the entry full with new data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full   <= 1'b0;
      data_q <= '0;
    end else if (enq_fire) begin
      full   <= 1'b1;
      data_q <= enq_msg;
    end else if (deq_fire) begin
      full   <= 1'b0;
    end
  end

  assign deq_val = full;
  assign deq_msg = data_q;

endmodule

// File: rtl/stream_demux14.sv
// rtl/stream_demux14.sv - 1-to-4 val/rdy stream router, one registered entry per output; DEMUX_COUNT_EN adds per-port accept counters
module stream_demux14
  import stream_demux_pkg::*;
#(
  parameter int p_nbits   = 32,
  parameter int p_cntbits = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [p_nbits-1:0]        recv_msg,
  input  logic [SEL_W-1:0]          recv_sel,
  input  logic                      recv_val,
  output logic                      recv_rdy,
  output logic [NPORTS*p_nbits-1:0] send_msg,
  output logic [NPORTS-1:0]         send_val,
  input  logic [NPORTS-1:0]         send_rdy
`ifdef DEMUX_COUNT_EN
  ,
  output logic [NPORTS*p_cntbits-1:0] count
`endif
);

  if (p_cntbits < 1) begin : g_bad_cntbits
    $error("stream_demux14: p_cntbits must be at least 1");
  end

  sel_t              sel;
  logic [NPORTS-1:0] sel_oh;
  logic [NPORTS-1:0] enq_rdy;
  logic              accept;

  // Decode the destination and pick that port's ready; other ports never gate the input
  always_comb begin
    sel      = recv_sel;
    sel_oh   = decode_sel(sel);
    recv_rdy = enq_rdy[sel];
    accept   = recv_val & recv_rdy;
  end

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    stream_pipe_reg1 #(
      .p_nbits(p_nbits)
    ) u_pipe (
      .clk     (clk),
      .reset   (reset),
      .enq_val (recv_val & sel_oh[i]),
      .enq_rdy (enq_rdy[i]),
      .enq_msg (recv_msg),
      .deq_val (send_val[i]),
      .deq_rdy (send_rdy[i]),
      .deq_msg (send_msg[i*p_nbits +: p_nbits])
    );
  end

`ifdef DEMUX_COUNT_EN
  logic [p_cntbits-1:0] cnt_q [NPORTS];

  // Count accepted messages per destination; wraps silently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPORTS; i++) cnt_q[i] <= '0;
    end else if (accept) begin
      cnt_q[sel] <= cnt_q[sel] + p_cntbits'(1);
    end
  end

  for (genvar i = 0; i < NPORTS; i++) begin : g_count
    assign count[i*p_cntbits +: p_cntbits] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_stream_demux14.sv
// tb/tb_stream_demux14.sv - directed and scoreboard bench for stream_demux14; DEMUX_COUNT_EN enables the counter checks
module tb_stream_demux14;

  localparam int NB = 32;
  localparam int CB = 4;

  logic          clk;
  logic          reset;
  logic [NB-1:0] recv_msg;
  logic [1:0]    recv_sel;
  logic          recv_val;
  logic          recv_rdy;
  logic [4*NB-1:0] send_msg;
  logic [3:0]    send_val;
  logic [3:0]    send_rdy;
`ifdef DEMUX_COUNT_EN
  logic [4*CB-1:0] count;
`endif

  int n_checks;
  int n_bad;

  stream_demux14 #(.p_nbits(NB), .p_cntbits(CB)) dut (
    .clk      (clk),
    .reset    (reset),
    .recv_msg (recv_msg),
    .recv_sel (recv_sel),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .send_msg (send_msg),
    .send_val (send_val),
    .send_rdy (send_rdy)
`ifdef DEMUX_COUNT_EN
    ,
    .count    (count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clean_reset();
    @(negedge clk);
    recv_val = 1'b0;
    reset    = 1'b1;
    #2;
    reset    = 1'b0;
  endtask

  task automatic test_reset();
    logic [NB-1:0] s2;
    reset = 1'b1; recv_val = 1'b0; recv_sel = 2'd0; recv_msg = '0; send_rdy = 4'h0;
    #2;
    n_checks++;
    if (send_val !== 4'b0000) begin n_bad++; $display("FAIL reset_val: got %b want 0000", send_val); end
    n_checks++;
    if (recv_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_rdy_during: got %b want 1", recv_rdy); end
    n_checks++;
    if (send_msg !== '0) begin n_bad++; $display("FAIL reset_msg: got %h want 0", send_msg); end
    @(negedge clk);
    reset = 1'b0;
    recv_sel = 2'd2; recv_msg = 32'h2222_2222; recv_val = 1'b1;
    @(posedge clk); #1;
    s2 = send_msg[2*NB +: NB];
    n_checks++;
    if (send_val !== 4'b0100 || s2 !== 32'h2222_2222) begin
      n_bad++; $display("FAIL reset_prefill: got val=%b msg=%h want val=0100 msg=22222222", send_val, s2);
    end
    recv_val = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (send_val !== 4'b0000) begin n_bad++; $display("FAIL reset_async: got %b want 0000", send_val); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (recv_rdy !== 1'b1 || send_val !== 4'b0000) begin
      n_bad++; $display("FAIL reset_release: got rdy=%b val=%b want rdy=1 val=0000", recv_rdy, send_val);
    end
`ifdef DEMUX_COUNT_EN
    n_checks++;
    if (count !== '0) begin n_bad++; $display("FAIL reset_count: got %h want 0", count); end
`endif
  endtask

  task automatic test_steering();
    logic [NB-1:0] msgs [4];
    logic [NB-1:0] s;
    logic [3:0]    want;
    msgs[0] = 32'hAAAA_0000; msgs[1] = 32'hBBBB_0001;
    msgs[2] = 32'hCCCC_0002; msgs[3] = 32'hDDDD_0003;
    send_rdy = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      recv_val = 1'b1; recv_sel = 2'(k); recv_msg = msgs[k];
      @(posedge clk); #1;
      want = 4'b0001 << k;
      s = send_msg[k*NB +: NB];
      n_checks++;
      if (send_val !== want || s !== msgs[k]) begin
        n_bad++; $display("FAIL steer_%0d: got val=%b msg=%h want val=%b msg=%h", k, send_val, s, want, msgs[k]);
      end
    end
    @(negedge clk);
    recv_val = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (send_val !== 4'b0000) begin n_bad++; $display("FAIL steer_drain: got %b want 0000", send_val); end
  endtask

  task automatic test_backpressure();
    logic [NB-1:0] s1, s3;
    send_rdy = 4'b1101;
    @(negedge clk);
    recv_val = 1'b1; recv_sel = 2'd1; recv_msg = 32'h11;
    @(posedge clk); #1;
    @(negedge clk);
    recv_msg = 32'h22;
    #1;
    n_checks++;
    if (recv_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_rdy_blocked: got %b want 0", recv_rdy); end
    @(posedge clk); #1;
    s1 = send_msg[1*NB +: NB];
    n_checks++;
    if (send_val !== 4'b0010 || s1 !== 32'h11) begin
      n_bad++; $display("FAIL bp_hold: got val=%b msg=%h want val=0010 msg=11", send_val, s1);
    end
    @(negedge clk);
    recv_sel = 2'd3; recv_msg = 32'h33;
    #1;
    n_checks++;
    if (recv_rdy !== 1'b1) begin n_bad++; $display("FAIL bp_rdy_other: got %b want 1", recv_rdy); end
    @(posedge clk); #1;
    s1 = send_msg[1*NB +: NB];
    s3 = send_msg[3*NB +: NB];
    n_checks++;
    if (send_val !== 4'b1010 || s1 !== 32'h11 || s3 !== 32'h33) begin
      n_bad++; $display("FAIL bp_switch: got val=%b p1=%h p3=%h want val=1010 p1=11 p3=33", send_val, s1, s3);
    end
    @(negedge clk);
    recv_val = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (send_val !== 4'b0010) begin n_bad++; $display("FAIL bp_p3_drain: got %b want 0010", send_val); end
    @(negedge clk);
    send_rdy = 4'hF;
    @(posedge clk); #1;
    n_checks++;
    if (send_val !== 4'b0000) begin n_bad++; $display("FAIL bp_release: got %b want 0000", send_val); end
  endtask

  task automatic test_fill_drain();
    logic [NB-1:0] s0;
    send_rdy = 4'hF;
    @(negedge clk);
    recv_val = 1'b1; recv_sel = 2'd0; recv_msg = 32'h5;
    @(posedge clk); #1;
    for (int k = 6; k <= 8; k++) begin
      @(negedge clk);
      recv_msg = NB'(k);
      #1;
      n_checks++;
      if (recv_rdy !== 1'b1) begin n_bad++; $display("FAIL fd_rdy_%0d: got %b want 1", k, recv_rdy); end
      @(posedge clk); #1;
      s0 = send_msg[0 +: NB];
      n_checks++;
      if (send_val !== 4'b0001 || s0 !== NB'(k)) begin
        n_bad++; $display("FAIL fd_msg_%0d: got val=%b msg=%h want val=0001 msg=%h", k, send_val, s0, k);
      end
    end
    @(negedge clk);
    recv_val = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (send_val !== 4'b0000) begin n_bad++; $display("FAIL fd_drain: got %b want 0000", send_val); end
  endtask

  task automatic test_random();
    logic [NB-1:0] q [4][$];
    logic          exp_rdy;
    logic [NB-1:0] s;
    logic [NB-1:0] front;
    int            errs;
    errs = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      recv_val = 1'($urandom_range(0, 1));
      recv_sel = 2'($urandom_range(0, 3));
      recv_msg = $urandom;
      send_rdy = 4'($urandom);
      #1;
      for (int i = 0; i < 4; i++) begin
        s = send_msg[i*NB +: NB];
        n_checks++;
        if (send_val[i] !== (q[i].size() != 0)) begin
          n_bad++; errs++;
          if (errs < 20) $display("FAIL rnd_val c=%0d p=%0d: got %b want %0d", c, i, send_val[i], q[i].size());
        end else if (q[i].size() != 0) begin
          front = q[i][0];
          n_checks++;
          if (s !== front) begin
            n_bad++; errs++;
            if (errs < 20) $display("FAIL rnd_msg c=%0d p=%0d: got %h want %h", c, i, s, front);
          end
        end
      end
      exp_rdy = (q[recv_sel].size() == 0) || send_rdy[recv_sel];
      n_checks++;
      if (recv_rdy !== exp_rdy) begin
        n_bad++; errs++;
        if (errs < 20) $display("FAIL rnd_rdy c=%0d: got %b want %b", c, recv_rdy, exp_rdy);
      end
      for (int i = 0; i < 4; i++)
        if (send_rdy[i] && q[i].size() != 0) void'(q[i].pop_front());
      if (recv_val && exp_rdy) q[recv_sel].push_back(recv_msg);
    end
    @(negedge clk);
    recv_val = 1'b0;
    send_rdy = 4'hF;
    for (int i = 0; i < 4; i++) q[i].delete();
    @(posedge clk); #1;
    n_checks++;
    if (send_val !== 4'b0000) begin n_bad++; $display("FAIL rnd_final: got %b want 0000", send_val); end
  endtask

`ifdef DEMUX_COUNT_EN
  task automatic test_count_wrap();
    clean_reset();
    send_rdy = 4'hF;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      recv_val = 1'b1; recv_sel = 2'd2; recv_msg = NB'(k);
      if (k == 0) begin
        recv_sel = 2'd2;
      end
    end
    @(negedge clk);
    recv_val = 1'b0;
    #1;
    n_checks++;
    if (count !== 16'h0100) begin n_bad++; $display("FAIL count_wrap: got %h want 0100", count); end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_bad    = 0;
    test_reset();
    test_steering();
    test_backpressure();
    test_fill_drain();
    test_random();
`ifdef DEMUX_COUNT_EN
    test_count_wrap();
`endif
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_demux14.md
Name: stream_demux14

Overview:
- 1-to-4 stream router; the write-side counterpart of the team's 4:1 data-select muxes.
- Accepts one val/rdy message per cycle on a single input stream. A 2-bit select steers the message to one of four output streams.
- Each output has a one-entry registered buffer, so latency is one cycle and the outputs are decoupled from each other.
- Sits in front of the per-lane processing units that later merge back through the 4:1 mux.

Parameters:
p_nbits, 32, message data width in bits
p_cntbits, 16, width of each per-output transaction counter (used only with DEMUX_COUNT_EN)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
recv_msg  input  p_nbits  input message data
recv_sel  input  2  destination port index 0..3; sampled with recv_msg
recv_val  input  1  input message valid
recv_rdy  output  1  block can accept the message addressed by recv_sel this cycle
send_msg  output  4*p_nbits  flattened output data; port i at bits [i*p_nbits +: p_nbits]
send_val  output  4  per-port output valid
send_rdy  input  4  per-port downstream ready
count  output  4*p_cntbits  per-port accepted-transaction counters (present only with DEMUX_COUNT_EN)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-high, named reset.
- Per-port state: full[i] (1 bit) and buf[i] (p_nbits).
- Reset values: full = 0, buf = 0, send_val = 4'b0000, send_msg = 0, count = 0. recv_rdy is combinational, so it is 1 during reset.
- Output drive: send_val[i] = full[i]; send_msg slice i = buf[i]. Both are registered outputs, with no combinational path from recv_*.
- Drain: drain[i] = send_val[i] & send_rdy[i].
- Ready: recv_rdy = ~full[recv_sel] | send_rdy[recv_sel]. This is a pipe-style bypass of ready; the combinational path send_rdy -> recv_rdy is intentional.
- Accept: accept = recv_val & recv_rdy. On accept, buf[recv_sel] <= recv_msg and full[recv_sel] <= 1.
- Per-port next state of full[i]:
  - fill only: 1
  - drain only: 0
  - fill and drain on the same port in the same cycle: stays 1, buf takes the new message
  - neither: hold
- Independence: ports not addressed by recv_sel drain independently in the same cycle. At most one fill per cycle.
- Latency: a message accepted in cycle N appears on send_* in cycle N+1.
- Throughput: one message/cycle sustained to any port whose downstream holds send_rdy = 1.
- Ordering: per-port order is FIFO (depth 1). There is no ordering guarantee across ports.
- Data stability: while send_val[i] = 1 and send_rdy[i] = 0, send_msg slice i and send_val[i] hold stable.
- Blocking:
  - A full, stalled destination port deasserts recv_rdy for messages addressed to it only.
  - Changing recv_sel while recv_val = 1 and recv_rdy = 0 is legal. Ready is re-evaluated for the new index.
- Idle input: recv_val = 0 causes no state change; recv_sel and recv_msg are don't-care.
- Reset mid-operation: all buffered messages are discarded; send_val drops to 0 immediately (asynchronously).
- Sequencing: there is no FSM beyond the per-port full flags.

Optional Feature:
- Macro: DEMUX_COUNT_EN.
- Defined:
  - count port exists; each p_cntbits counter increments on every accept to that port.
  - Counters wrap from 2^p_cntbits-1 to 0 with no saturation or flag.
  - Reset to 0.
- Undefined:
  - count port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package stream_demux_pkg holds:
  - NPORTS = 4
  - SEL_W = 2
  - typedef sel_t (logic [SEL_W-1:0])
- One natural sub-module: stream_pipe_reg1, a single-entry val/rdy pipeline register with enq_val/enq_rdy/enq_msg and deq_val/deq_rdy/deq_msg. It is instantiated four times with enq_val = recv_val & (recv_sel == i).
- Select decode and recv_rdy mux stay in the top.

Test Plan:
- Reset: assert reset mid-stream with port 2 full -> send_val = 0000 asynchronously. After release, recv_rdy = 1 and count = 0.
- Steering: send 0xAAAA0000, 0xBBBB0001, 0xCCCC0002, 0xDDDD0003 with sel 0, 1, 2, 3 on consecutive cycles, all send_rdy = 1 -> each appears one cycle later on its port only; other send_val bits are 0.
- Back-pressure: send_rdy[1] = 0, send 0x11 then 0x22 to sel 1 -> 0x11 held on port 1; recv_rdy = 0 for sel 1. Switch sel to 3 -> recv_rdy = 1 and port 3 receives the message.
- Simultaneous fill/drain: port 0 full with 0x5, send_rdy[0] = 1, accept 0x6 to sel 0 in the same cycle -> 0x5 consumed, send_val[0] stays 1 with 0x6 next cycle, one message/cycle sustained.
- Random: 10k cycles of random recv_val/recv_sel/send_rdy against a scoreboard model -> per-port FIFO order exact, no loss or duplication.
- Counter wrap (DEMUX_COUNT_EN, p_cntbits = 4): 17 accepts to port 2 -> count slice 2 reads 1; other slices 0.
